// File: rtl/block_data_memory.sv
// Block data memory: 64 little-endian 4-byte blocks with a fixed ACCESS_CYCLES access latency.
// Define DMEM_STATS_EN to add saturating read_count/write_count access counters.
module block_data_memory #(
    parameter int unsigned ACCESS_CYCLES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] read_count,
    output logic [15:0] write_count
`endif
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CountLoad = 4'(ACCESS_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  count_q;
    logic        op_write_q;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  mem_q [256];
    logic        access_done;

    assign access_done = (state_q == StBusy) && (count_q == 4'd0);

    // Busy is combinational in IDLE so the cache stalls in the same cycle it raises a request.
    always_comb begin
        busywait = 1'b0;
        case (state_q)
            StIdle:  busywait = read | write;
            StBusy:  busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= 6'd0;
            wdata_q    <= 32'h0;
            readdata   <= 32'h0;
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (read | write) begin
                        op_write_q <= write;
                        addr_q     <= address;
                        wdata_q    <= writedata;
                        count_q    <= CountLoad;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    if (access_done) begin
                        if (op_write_q) begin
                            mem_q[{addr_q, 2'd0}] <= wdata_q[7:0];
                            mem_q[{addr_q, 2'd1}] <= wdata_q[15:8];
                            mem_q[{addr_q, 2'd2}] <= wdata_q[23:16];
                            mem_q[{addr_q, 2'd3}] <= wdata_q[31:24];
                        end else begin
                            readdata <= {mem_q[{addr_q, 2'd3}], mem_q[{addr_q, 2'd2}],
                                         mem_q[{addr_q, 2'd1}], mem_q[{addr_q, 2'd0}]};
                        end
                        state_q <= StDone;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            read_count  <= 16'h0;
            write_count <= 16'h0;
        end else if (access_done) begin
            if (op_write_q) begin
                if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            end else begin
                if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 Parameter ACCESS_CYCLES, default 5, number of BUSY cycles per access; legal range 1..15.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 read  input  1  cache requests a block read.
REQ-005 write  input  1  cache requests a block write.
REQ-006 address  input  6  block address; bytes {address,2'b00}..{address,2'b11}.
REQ-007 writedata  input  32  block write data.
REQ-008 readdata  output  32  block read data, registered.
REQ-009 busywait  output  1  memory busy; the cache holds its request while high.

Function
REQ-010 Storage: 256 bytes as 64 blocks of 4 bytes; little-endian, so writedata[8k+7:8k] maps to byte 4*address+k, k=0..3, and readdata uses the same mapping.
REQ-011 FSM states: IDLE, BUSY, DONE; 4-bit down-counter; request registers for op, address and writedata.
REQ-012 IDLE: busywait = read|write, combinational, so the cache sees busy in the same cycle it raises a request.
REQ-013 IDLE with read|write at the edge: latch op, address and writedata; load counter with ACCESS_CYCLES-1; go to BUSY.
REQ-014 Simultaneous read and write in IDLE: treat as a write; readdata unchanged.
REQ-015 BUSY: busywait=1; counter decrements each edge; read/write/address/writedata changes ignored (latched values used).
REQ-016 BUSY with counter==0 at the edge: perform the access, then go to DONE.
REQ-017 Access on a read: readdata <= the addressed block.
REQ-018 Access on a write: the addressed block <= latched writedata.
REQ-019 DONE: busywait=0; read/write ignored; unconditional transition to IDLE next edge.
REQ-020 DONE lets the cache leave its memory state before a held request is re-sampled, so one request never causes a double access.
REQ-021 Latency: a request raised in cycle t gives busywait=1 for cycles t..t+ACCESS_CYCLES and busywait=0 in cycle t+ACCESS_CYCLES+1 (DONE).
REQ-022 Read data is valid in the DONE cycle.
REQ-023 readdata holds its value until the next completed read.
REQ-024 Back-to-back requests (write-back followed by fetch): a request present in the IDLE cycle after DONE is accepted per REQ-013 with no extra gap.

Reset
REQ-025 reset at an edge, in any state: state=IDLE, counter=0, readdata=32'h0, all 64 blocks cleared to 0.
REQ-026 Reset mid-BUSY aborts the access; no array write and no readdata update occur.
REQ-027 In the cycle after reset is released, busywait follows REQ-012.

Configuration
REQ-028 Macro DMEM_STATS_EN adds outputs read_count[15:0] and write_count[15:0].
REQ-029 With DMEM_STATS_EN, each counter increments by one at each completed read or write access, saturates at 16'hFFFF, and resets to 0.
REQ-030 Without DMEM_STATS_EN, those ports and counters do not exist; all other behaviour is identical.

Verification (ACCESS_CYCLES=5)
REQ-031 Assert reset 2 cycles, then read block 0 -> readdata=0 and busywait=0 immediately after reset; read completes with readdata=32'h0.
REQ-032 Write 32'hDEADBEEF to block 6'h2A, raised in cycle 0 -> busywait=1 in cycles 0-5 and 0 in cycle 6; a later read of 6'h2A returns 32'hDEADBEEF in its DONE cycle, with byte 168=8'hEF.
REQ-033 Write block 5=32'h11223344, held until busywait drops, then read block 9 raised in the IDLE cycle after DONE -> exactly one write and one read; second busywait pulse starts with no gap; readdata=block 9 contents.
REQ-034 Read and write both high, block 3, writedata 32'hCAFEF00D -> block 3=32'hCAFEF00D; readdata keeps its prior value.
REQ-035 Write 32'hFFFFFFFF to block 7, reset in the third BUSY cycle -> busywait=0 in the next cycle; a later read of block 7 returns 32'h0.
REQ-036 With DMEM_STATS_EN, 3 reads and 2 writes -> read_count=3, write_count=2; after reset both =0.
